// File: rtl/prewish_dip_loader_pkg.sv
// prewish_dip_loader_pkg: shared FSM encodings, default debounce width and pin polarity helper.
package prewish_dip_loader_pkg;
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] PRESSED = 2'b01;
    localparam logic [1:0] EMIT    = 2'b10;
    localparam int DEFAULT_DEBOUNCE_BITS = 16;
    function automatic logic [7:0] normalize(input logic [7:0] pins, input bit active_low);
        return active_low ? ~pins : pins;
    endfunction
endpackage

// File: rtl/prewish_dip_loader_debounce.sv
// prewish_debounce: 2-flop synchronizer plus run-length debouncer; o_level is 1 while pressed.
module prewish_debounce import prewish_dip_loader_pkg::*; #(
    parameter int DEBOUNCE_BITS = DEFAULT_DEBOUNCE_BITS,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic i_raw,
    output logic o_level
);
    logic s1, s2, sync;
    logic [DEBOUNCE_BITS-1:0] cnt;
    assign sync = s2 ^ ACTIVE_LOW;
    // a flip needs 2^DEBOUNCE_BITS consecutive samples that disagree with o_level
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            s1      <= ACTIVE_LOW;
            s2      <= ACTIVE_LOW;
            cnt     <= '0;
            o_level <= 1'b0;
        end else begin
            s1 <= i_raw;
            s2 <= s1;
            if (sync == o_level) begin
                cnt <= '0;
            end else if (&cnt) begin
                o_level <= sync;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/prewish_dip_loader.sv
// prewish_dip_loader: snapshots the DIP bank on each debounced LOAD release and emits it with a one-cycle strobe.
module prewish_dip_loader import prewish_dip_loader_pkg::*; #(
    parameter int DEBOUNCE_BITS  = DEFAULT_DEBOUNCE_BITS,
    parameter bit DIP_ACTIVE_LOW = 1'b1,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [7:0] i_dip,
    input  logic       i_load_btn,
    output logic       STB_O,
    output logic [7:0] DAT_O,
    output logic       o_alive
);
    logic [7:0] dip_s1, dip_s2;
    logic [1:0] state;
    logic       level;
    prewish_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_btn (
        .CLK_I(CLK_I), .RST_I(RST_I), .i_raw(i_load_btn), .o_level(level)
    );
    assign o_alive = level;
    // STB_O is registered off EMIT, so it is high the cycle after EMIT
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            dip_s1 <= {8{DIP_ACTIVE_LOW}};
            dip_s2 <= {8{DIP_ACTIVE_LOW}};
            state  <= IDLE;
            STB_O  <= 1'b0;
            DAT_O  <= 8'h00;
        end else begin
            dip_s1 <= i_dip;
            dip_s2 <= dip_s1;
            STB_O  <= state == EMIT;
            state  <= state == IDLE    ? (level ? PRESSED : IDLE) :
                      state == PRESSED ? (level ? PRESSED : EMIT) : IDLE;
            if (state == PRESSED && !level)
                DAT_O <= normalize(dip_s2, DIP_ACTIVE_LOW);
        end
    end
endmodule

// File: tb/tb_prewish_dip_loader.sv
// tb_prewish_dip_loader: randomized scoreboard bench with a sample-window reference model of debounce and capture.
module tb_prewish_dip_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dip = 8'hFF;
    logic       btn = 1'b1;
    logic       stb;
    logic [7:0] dat;
    logic       alive;
    int checks = 0;
    int errors = 0;
    int stb_count = 0;
    typedef struct { int due; logic [7:0] data; } exp_t;
    exp_t sb[$];
    bit         hist[$];
    logic [7:0] dhist[$];
    bit         lvl = 1'b0;
    logic [7:0] dat_model = 8'h00;
    int         ecnt = 0;
    int         cap_edge = -1;
    logic [7:0] cap_data = 8'h00;
    bit         flip;
    int         k;
    prewish_dip_loader #(.DEBOUNCE_BITS(3), .DIP_ACTIVE_LOW(1'b1), .BTN_ACTIVE_LOW(1'b1)) dut (
        .CLK_I(clk), .RST_I(rst_n), .i_dip(dip), .i_load_btn(btn),
        .STB_O(stb), .DAT_O(dat), .o_alive(alive)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // reference: the level flips once the last 8 synchronized samples (2 edges old) all disagree with it
    always @(posedge clk) if (rst_n) begin
        ecnt++;
        if (ecnt == cap_edge) dat_model = cap_data;
        hist.push_back(!btn);
        dhist.push_back(~dip);
        k = hist.size();
        flip = k >= 10;
        for (int j = k - 10; j <= k - 3 && flip; j++)
            if (hist[j] == lvl) flip = 1'b0;
        if (flip) begin
            lvl = !lvl;
            if (!lvl) begin
                sb.push_back('{ecnt + 2, dhist[k - 2]});
                cap_edge = ecnt + 1;
                cap_data = dhist[k - 2];
            end
        end
    end
    always @(negedge rst_n) begin
        hist.delete(); dhist.delete(); sb.delete();
        lvl = 1'b0; dat_model = 8'h00; ecnt = 0; cap_edge = -1;
    end
    always @(negedge clk) if (rst_n) begin
        chk("alive", alive, lvl);
        chk("dat_hold", dat, dat_model);
        if (stb) begin
            stb_count++;
            if (sb.size() == 0) chk("unexpected_stb", 1, 0);
            else begin
                chk("stb_edge", ecnt, sb[0].due);
                chk("stb_dat", dat, sb[0].data);
                void'(sb.pop_front());
            end
        end else if (sb.size() != 0 && sb[0].due <= ecnt) begin
            chk("missing_stb", 0, 1);
            void'(sb.pop_front());
        end
    end
    task automatic hold(input logic b, input int n);
        btn = b;
        repeat (n) @(negedge clk);
    endtask
    initial begin
        int n, s;
        #1;
        chk("reset_stb", stb, 0);
        chk("reset_dat", dat, 0);
        chk("reset_alive", alive, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1, 5);
        dip = 8'b01010111;
        hold(0, 40);
        chk("clean_alive_held", alive, 1);
        btn = 1'b1;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            if (stb) n = i;
        end
        chk("clean_latency", n, 12);
        chk("clean_dat", dat, 8'hA8);
        hold(1, 10);
        s = stb_count;
        for (int i = 0; i < 10; i++) hold(i % 2 ? 1'b1 : 1'b0, 3);
        hold(0, 20);
        for (int i = 0; i < 10; i++) hold(i % 2 ? 1'b0 : 1'b1, 3);
        hold(1, 20);
        chk("bounce_strobes", stb_count - s, 1);
        s = stb_count;
        hold(0, 7);
        hold(1, 25);
        chk("glitch_strobes", stb_count - s, 0);
        dip = 8'hFF;
        hold(0, 20);
        dip = 8'h35;
        hold(0, 20);
        hold(1, 20);
        chk("snapshot_dat", dat, 8'hCA);
        s = stb_count;
        dip = 8'($urandom);
        hold(0, 500);
        chk("long_hold_nostb", stb_count - s, 0);
        hold(1, 20);
        chk("long_hold_stb", stb_count - s, 1);
        dip = 8'($urandom);
        hold(0, 15);
        btn = 1'b1;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            if (stb) n = i;
        end
        chk("emit_seen", n != 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("emit_reset_stb", stb, 0);
        chk("emit_reset_dat", dat, 0);
        chk("emit_reset_alive", alive, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s = stb_count;
        hold(1, 30);
        chk("post_reset_nostb", stb_count - s, 0);
        btn = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("held_reset_alive", alive, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            @(negedge clk);
            if (alive) n = i;
        end
        chk("held_reset_alive_edges", n, 10);
        dip = 8'($urandom);
        hold(0, 5);
        s = stb_count;
        hold(1, 20);
        chk("held_reset_stb", stb_count - s, 1);
        for (int r = 0; r < 25; r++) begin
            dip = 8'($urandom);
            for (int b = $urandom_range(0, 5); b > 0; b--) hold(1'($urandom), $urandom_range(1, 6));
            hold(0, $urandom_range(3, 25));
            dip = 8'($urandom);
            hold(0, $urandom_range(1, 10));
            hold(1, $urandom_range(3, 25));
        end
        hold(1, 30);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
